hamming_serial_rx: RTL and testbench

- Bit-serial Hamming(15,11) receiver for the link side of the block-code path.
- Shifts in one 15-bit codeword per frame, one bit per cycle, position 1 first.
- Builds the syndrome on the fly, corrects any single-bit error, extracts the 11 data bits, and presents them on a valid/ready output port.
- Counts corrected frames and flags overruns and framing errors.

---
 rtl/hamming_pkg.sv | 20 ++
 rtl/hamming_serial_rx_if.sv | 27 ++
 rtl/hamming_correct.sv | 23 ++
 rtl/hamming_serial_rx.sv | 102 ++++++++++
 tb/tb_hamming_serial_rx.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) definitions for the serial receiver and the parallel decoder.
// Codeword positions are numbered 15:1 and parity bits sit at positions 1, 2, 4 and 8.
package hamming_pkg;
  localparam int CW    = 15;
  localparam int DW    = 11;
  localparam int SYN_W = 4;

  typedef logic [SYN_W-1:0] syn_t;
  typedef logic [CW:1]      cw_t;

  localparam syn_t P1 = 4'd1;
  localparam syn_t P2 = 4'd2;
  localparam syn_t P4 = 4'd4;
  localparam syn_t P8 = 4'd8;

  // Data occupies every non-parity position, highest position first.
  function automatic logic [DW-1:0] extract_data(input cw_t cw);
    return {cw[15:9], cw[7:5], cw[3]};
  endfunction
endpackage

// File: rtl/hamming_serial_rx_if.sv
// Serial input and decoded-word output bundle of the Hamming serial receiver.
// The serial side has valid only; the output transfers when m_valid && m_ready, and m_* hold until then.
interface hamming_serial_rx_if #(
  parameter int CNT_W = 8
);
  logic                       s_valid;
  logic                       s_sof;
  logic                       s_bit;
  logic                       m_valid;
  logic                       m_ready;
  logic [hamming_pkg::DW-1:0] m_data;
  logic                       m_corrected;
  hamming_pkg::syn_t          m_syndrome;
  logic                       overrun;
  logic                       frame_err;
  logic [CNT_W-1:0]           corr_count;

  modport master (
    output s_valid, s_sof, s_bit, m_ready,
    input  m_valid, m_data, m_corrected, m_syndrome, overrun, frame_err, corr_count
  );

  modport slave (
    input  s_valid, s_sof, s_bit, m_ready,
    output m_valid, m_data, m_corrected, m_syndrome, overrun, frame_err, corr_count
  );
endinterface

// File: rtl/hamming_correct.sv
// Combinational single-error corrector: flips the codeword bit named by the syndrome
// and extracts the data field.
module hamming_correct
  import hamming_pkg::*;
(
  input  cw_t           i_cw,
  input  syn_t          i_syn,
  output logic [DW-1:0] o_data,
  output logic          o_corrected
);
  cw_t w_fixed;

  // A zero syndrome never matches a position, so clean words pass unchanged.
  always_comb begin
    w_fixed = i_cw;
    for (int i = 1; i <= CW; i++) begin
      if (i_syn == syn_t'(i)) w_fixed[i] = ~i_cw[i];
    end
  end

  assign o_data      = extract_data(w_fixed);
  assign o_corrected = (i_syn != '0);
endmodule

// File: rtl/hamming_serial_rx.sv
// Bit-serial Hamming(15,11) receiver: accumulates the syndrome as bits arrive, corrects
// on the last bit and holds the decoded word until the consumer takes it.
module hamming_serial_rx
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  hamming_serial_rx_if.slave  bus,
  output logic [0:0]          o_state
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [3:0]       r_pos;
  syn_t             r_syn;
  logic [CW-1:1]    r_cw;
  logic             r_m_valid;
  logic [DW-1:0]    r_m_data;
  syn_t             r_m_syn;
  logic             r_m_corr;
  logic             r_overrun;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_cnt;

  syn_t          w_final_syn;
  cw_t           w_full_cw;
  logic          w_slot_free;
  logic [DW-1:0] w_data;
  logic          w_corr;

  // Bit 15 is still on the wire when the frame completes, so it joins the word here.
  assign w_final_syn = r_syn ^ (bus.s_bit ? 4'd15 : 4'd0);
  assign w_full_cw   = {bus.s_bit, r_cw};
  assign w_slot_free = ~r_m_valid | bus.m_ready;

  hamming_correct u_correct (
    .i_cw        (w_full_cw),
    .i_syn       (w_final_syn),
    .o_data      (w_data),
    .o_corrected (w_corr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pos       <= 4'd1;
      r_syn       <= '0;
      r_cw        <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_syn     <= '0;
      r_m_corr    <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_frame_err <= 1'b0;
      if (r_m_valid && bus.m_ready) r_m_valid <= 1'b0;
      if (bus.s_valid) begin
        if (bus.s_sof) begin
          // A start-of-frame always restarts at position 1; mid-frame it also aborts.
          r_frame_err <= (r_state == SHIFT);
          r_state     <= SHIFT;
          r_cw        <= {{(CW-2){1'b0}}, bus.s_bit};
          r_pos       <= 4'd2;
          r_syn       <= bus.s_bit ? 4'd1 : 4'd0;
        end else if (r_state == SHIFT) begin
          if (r_pos == 4'd15) begin
            r_state <= IDLE;
            r_pos   <= 4'd1;
            r_syn   <= '0;
            if (w_slot_free) begin
              r_m_valid <= 1'b1;
              r_m_data  <= w_data;
              r_m_syn   <= w_final_syn;
              r_m_corr  <= w_corr;
              if (w_corr && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end else begin
            r_cw[r_pos] <= bus.s_bit;
            r_syn       <= r_syn ^ (bus.s_bit ? r_pos : 4'd0);
            r_pos       <= r_pos + 4'd1;
          end
        end
      end
    end
  end

  assign bus.m_valid     = r_m_valid;
  assign bus.m_data      = r_m_data;
  assign bus.m_syndrome  = r_m_syn;
  assign bus.m_corrected = r_m_corr;
  assign bus.overrun     = r_overrun;
  assign bus.frame_err   = r_frame_err;
  assign bus.corr_count  = r_cnt;
  assign o_state         = r_state;
endmodule

// File: tb/tb_hamming_serial_rx.sv
// Directed bench for hamming_serial_rx: an 8-bit and a 2-bit counter instance share one
// stimulus stream; expected words queue on send and are compared when the DUT presents them.
module tb_hamming_serial_rx;
  import hamming_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hamming_serial_rx_if #(.CNT_W(8)) bus8 ();
  hamming_serial_rx_if #(.CNT_W(2)) bus2 ();

  assign bus2.s_valid = bus8.s_valid;
  assign bus2.s_sof   = bus8.s_sof;
  assign bus2.s_bit   = bus8.s_bit;
  assign bus2.m_ready = bus8.m_ready;

  logic [0:0] st8;
  logic [0:0] st2;

  hamming_serial_rx #(.CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8), .o_state(st8));
  hamming_serial_rx #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .o_state(st2));

  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_cnt8 = 0;
  int exp_cnt2 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus8.s_valid = 1'b0;
    bus8.s_sof   = 1'b0;
    bus8.s_bit   = 1'b0;
  endtask

  // Drives positions first..last of cw (position p is cw[p-1]); returns at the negedge
  // after the last bit was clocked in, with that bit still on the wire.
  task automatic send_range(input logic [14:0] cw, input int first, input int last,
                            input int max_gap);
    for (int p = first; p <= last; p++) begin
      if (p != first && max_gap > 0) begin
        idle();
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      end
      bus8.s_valid = 1'b1;
      bus8.s_sof   = (p == 1);
      bus8.s_bit   = cw[p-1];
      @(negedge clk);
    end
  endtask

  task automatic expect_word(input logic [10:0] d, input logic [3:0] s);
    exp_q.push_back({(s != 4'd0), s, d});
    if (s != 4'd0) begin
      exp_cnt8++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
  endtask

  task automatic check_held(input string tag);
    logic [15:0] e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s_queue observed=empty expected=word", tag);
    end
    e = (exp_q.size() != 0) ? exp_q[0] : 16'h0;
    chk({tag, "_valid"}, bus8.m_valid, 1'b1);
    chk({tag, "_data"}, bus8.m_data, e[10:0]);
    chk({tag, "_syn"}, bus8.m_syndrome, e[14:11]);
    chk({tag, "_corr"}, bus8.m_corrected, e[15]);
    chk({tag, "_cnt8"}, bus8.corr_count, exp_cnt8);
    chk({tag, "_cnt2"}, bus2.corr_count, exp_cnt2);
    chk({tag, "_data2"}, bus2.m_data, e[10:0]);
  endtask

  task automatic consume(input string tag);
    idle();
    bus8.m_ready = 1'b1;
    @(negedge clk);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    chk({tag, "_drop"}, bus8.m_valid, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, bus8.m_valid, 1'b0);
    chk({tag, "_data"}, bus8.m_data, 11'h0);
    chk({tag, "_syn"}, bus8.m_syndrome, 4'h0);
    chk({tag, "_corr"}, bus8.m_corrected, 1'b0);
    chk({tag, "_ovr"}, bus8.overrun, 1'b0);
    chk({tag, "_ferr"}, bus8.frame_err, 1'b0);
    chk({tag, "_cnt8"}, bus8.corr_count, 8'h0);
    chk({tag, "_cnt2"}, bus2.corr_count, 2'h0);
    chk({tag, "_state"}, st8, 1'b0);
  endtask

  initial begin
    logic [14:0] cw;
    idle();
    bus8.m_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    bus8.m_ready = 1'b1;

    // Clean frame
    expect_word(11'h001, 4'd0);
    send_range(15'h0007, 1, 15, 0);
    check_held("clean");
    chk("clean_ferr", bus8.frame_err, 1'b0);
    chk("clean_state", st8, 1'b0);
    consume("clean");

    // Single data-bit error at position 3
    expect_word(11'h001, 4'd3);
    send_range(15'h0003, 1, 15, 0);
    check_held("err3");
    consume("err3");

    // Parity-position error at position 8 with random gaps
    expect_word(11'h7FF, 4'd8);
    send_range(15'h7F7F, 1, 15, 3);
    check_held("err8");
    consume("err8");

    // Back-to-back frames with the consumer stalled
    bus8.m_ready = 1'b0;
    expect_word(11'h001, 4'd0);
    send_range(15'h0007, 1, 15, 0);
    check_held("b2b_first");
    send_range(15'h7FFF, 1, 15, 0);
    check_held("b2b_held");
    chk("b2b_ovr", bus8.overrun, 1'b1);
    consume("b2b");
    chk("b2b_empty", exp_q.size(), 0);

    // Start-of-frame reasserted mid-frame
    send_range(15'h7FFF, 1, 6, 0);
    chk("sof_state", st8, 1'b1);
    send_range(15'h7FFF, 1, 1, 0);
    chk("sof_ferr_hi", bus8.frame_err, 1'b1);
    chk("sof_nodeliver", bus8.m_valid, 1'b0);
    send_range(15'h7FFF, 2, 2, 0);
    chk("sof_ferr_lo", bus8.frame_err, 1'b0);
    expect_word(11'h7FF, 4'd0);
    send_range(15'h7FFF, 3, 15, 0);
    check_held("sof_frame");
    chk("sof_ovr_sticky", bus8.overrun, 1'b1);
    consume("sof");

    // Five corrupted frames: the 2-bit counter saturates, the 8-bit one keeps counting
    for (int k = 0; k < 5; k++) begin
      int p;
      p = (k == 0) ? 1 : (k == 1) ? 5 : (k == 2) ? 9 : (k == 3) ? 12 : 15;
      cw = 15'h7FFF ^ (15'h1 << (p - 1));
      expect_word(11'h7FF, 4'(p));
      send_range(cw, 1, 15, 2);
      check_held("sat");
      consume("sat");
    end
    chk("sat_cnt2", bus2.corr_count, 2'd3);
    chk("sat_cnt8", bus8.corr_count, 8'd7);

    // Reset with a held word and a partial frame in flight
    bus8.m_ready = 1'b0;
    expect_word(11'h7FF, 4'd0);
    send_range(15'h7FFF, 1, 15, 0);
    check_held("pre_rst");
    send_range(15'h0007, 1, 8, 0);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    check_zero("mid_rst");
    exp_q.delete();
    exp_cnt8 = 0;
    exp_cnt2 = 0;
    rst_n = 1'b1;
    bus8.m_ready = 1'b1;
    expect_word(11'h001, 4'd10);
    send_range(15'h0207, 1, 15, 0);
    check_held("post_rst");
    consume("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
